// File: rtl/multi_cycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle sequencer and the MIPS-subset datapath.
//   op, func   : instruction fields taken from the instruction register
//   zero, sign : ALU flags, only looked at while a branch is resolving
//   PCWre .. ALUOp : control set produced by the sequencer
// Modports:
//   master : the sequencer (reads IR/flags, drives the controls)
//   slave  : the datapath side (drives IR/flags, reads the controls)
interface multi_cycle_ctrl_fsm_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       sign;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRw;
    logic       RegWre;
    logic       ExtSel;
    logic       RegDst;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;

    modport master (
        input  op, func, zero, sign,
        output PCWre, IRWre, InsMemRw, RegWre, ExtSel, RegDst, ALUSrcA, ALUSrcB,
               DBDataSrc, mRD, mWR, PCSrc, ALUOp
    );

    modport slave (
        output op, func, zero, sign,
        input  PCWre, IRWre, InsMemRw, RegWre, ExtSel, RegDst, ALUSrcA, ALUSrcB,
               DBDataSrc, mRD, mWR, PCSrc, ALUOp
    );
endinterface

// File: rtl/multi_cycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Walks each instruction through IF/ID/EXE/MEM/WB (plus MWB for lw, BR for
// branches, HALT as a parking state) and drives the datapath controls.
// Ports:
//   CLK       : rising-edge clock
//   Reset     : asynchronous active-low reset
//   bus       : control bus (IR fields and flags in, control set out)
//   state     : current state, for debug
//   instr_cnt : retired-instruction count, +1 per PCWre pulse, wraps
module multi_cycle_ctrl_fsm #(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter logic [5:0] BEQ_OP  = 6'b110000,
    parameter int         CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    multi_cycle_ctrl_fsm_if.master bus,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     instr_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_WB   = 3'd3,
        S_MEM  = 3'd4,
        S_MWB  = 3'd5,
        S_BR   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t state_reg;

    // Instruction decode
    logic is_rtype, is_sll, is_addiu, is_andi, is_ori, is_slti;
    logic is_lw, is_sw, is_beq, is_bne, is_bltz, is_j, is_halt;
    logic is_imm, is_branch, is_exec;
    logic br_taken;
    logic pc_wre;
    logic [2:0] alu_code;

    always_comb begin
        is_rtype  = (bus.op == OP_RTYPE) &&
                    ((bus.func == FN_ADD) || (bus.func == FN_SUB) || (bus.func == FN_AND) ||
                     (bus.func == FN_OR)  || (bus.func == FN_SLL));
        is_sll    = is_rtype && (bus.func == FN_SLL);
        is_addiu  = (bus.op == OP_ADDIU);
        is_andi   = (bus.op == OP_ANDI);
        is_ori    = (bus.op == OP_ORI);
        is_slti   = (bus.op == OP_SLTI);
        is_lw     = (bus.op == OP_LW);
        is_sw     = (bus.op == OP_SW);
        is_beq    = (bus.op == BEQ_OP);
        is_bne    = (bus.op == OP_BNE);
        is_bltz   = (bus.op == OP_BLTZ);
        is_j      = (bus.op == OP_J);
        is_halt   = (bus.op == HALT_OP);
        is_imm    = is_addiu || is_andi || is_ori || is_slti;
        is_branch = is_beq || is_bne || is_bltz;
        // Anything that needs the EXE state; everything else that is not
        // j/halt/branch retires as a NOP straight out of ID.
        is_exec   = is_rtype || is_imm || is_lw || is_sw;
        br_taken  = (is_beq && bus.zero) || (is_bne && !bus.zero) || (is_bltz && bus.sign);
    end

    // ALU operation for the current instruction, independent of state
    always_comb begin
        alu_code = ALU_NONE;
        if (is_rtype) begin
            case (bus.func)
                FN_ADD:  alu_code = ALU_ADD;
                FN_SUB:  alu_code = ALU_SUB;
                FN_AND:  alu_code = ALU_AND;
                FN_OR:   alu_code = ALU_OR;
                FN_SLL:  alu_code = ALU_SLL;
                default: alu_code = ALU_NONE;
            endcase
        end else if (is_addiu || is_lw || is_sw) begin
            alu_code = ALU_ADD;
        end else if (is_andi) begin
            alu_code = ALU_AND;
        end else if (is_ori) begin
            alu_code = ALU_OR;
        end else if (is_slti) begin
            alu_code = ALU_SLT;
        end else if (is_branch) begin
            alu_code = ALU_SUB;
        end
    end

    // PC update pulse in the last state of each instruction. Unknown opcodes
    // retire from ID like j, just with a sequential PC.
    always_comb begin
        pc_wre = 1'b0;
        case (state_reg)
            S_ID:    pc_wre = is_j || (!is_halt && !is_branch && !is_exec);
            S_WB,
            S_MWB,
            S_BR:    pc_wre = 1'b1;
            S_MEM:   pc_wre = is_sw;
            default: pc_wre = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IF;
            instr_cnt <= '0;
        end else begin
            if (pc_wre) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
            case (state_reg)
                S_IF: state_reg <= S_ID;
                S_ID: begin
                    if (is_halt) begin
                        state_reg <= S_HALT;
                    end else if (is_branch) begin
                        state_reg <= S_BR;
                    end else if (is_exec) begin
                        state_reg <= S_EXE;
                    end else begin
                        state_reg <= S_IF;
                    end
                end
                S_EXE:   state_reg <= (is_lw || is_sw) ? S_MEM : S_WB;
                S_MEM:   state_reg <= is_lw ? S_MWB : S_IF;
                S_WB,
                S_MWB,
                S_BR:    state_reg <= S_IF;
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_IF;
            endcase
        end
    end

    assign state = state_reg;

    // Control outputs. Strobes are gated with Reset so they drop the moment
    // reset asserts, without waiting for the state register to settle.
    always_comb begin
        bus.InsMemRw  = 1'b1;
        bus.PCWre     = Reset && pc_wre;
        bus.IRWre     = Reset && (state_reg == S_IF);
        bus.RegWre    = Reset && ((state_reg == S_WB) || (state_reg == S_MWB));
        bus.mRD       = Reset && (state_reg == S_MEM) && is_lw;
        bus.mWR       = Reset && (state_reg == S_MEM) && is_sw;
        bus.ExtSel    = !(is_andi || is_ori);
        bus.RegDst    = is_rtype;
        bus.ALUSrcA   = is_sll;
        bus.ALUSrcB   = is_imm || is_lw || is_sw;
        bus.DBDataSrc = is_lw;

        bus.PCSrc = 2'b00;
        if (Reset) begin
            if ((state_reg == S_ID) && is_j) begin
                bus.PCSrc = 2'b10;
            end else if ((state_reg == S_BR) && br_taken) begin
                bus.PCSrc = 2'b01;
            end
        end

        bus.ALUOp = ALU_NONE;
        if (Reset) begin
            case (state_reg)
                S_EXE, S_MEM, S_MWB, S_WB, S_BR: bus.ALUOp = alu_code;
                default:                         bus.ALUOp = ALU_NONE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
module tb_multi_cycle_ctrl_fsm;

    logic        CLK;
    logic        Reset;
    logic [2:0]  state;
    logic [15:0] instr_cnt;

    multi_cycle_ctrl_fsm_if bus_if ();

    multi_cycle_ctrl_fsm #(.CNT_W(16)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus_if),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: instruction classes and their architectural effects
    typedef enum int {K_R, K_IMM, K_LW, K_SW, K_BR, K_J, K_NOP, K_HALT} kind_t;

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000: return K_R;
                    default: return K_NOP;
                endcase
            end
            6'b001001, 6'b001000, 6'b001101, 6'b001010: return K_IMM;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b110000, 6'b000101, 6'b000001: return K_BR;
            6'b000010: return K_J;
            6'b111111: return K_HALT;
            default:   return K_NOP;
        endcase
    endfunction

    function automatic logic [2:0] alu_expect(input logic [5:0] o, input logic [5:0] f);
        case (classify(o, f))
            K_R: begin
                case (f)
                    6'b100000: return 3'b000;
                    6'b100010: return 3'b001;
                    6'b100100: return 3'b100;
                    6'b100101: return 3'b011;
                    default:   return 3'b010;
                endcase
            end
            K_IMM: begin
                case (o)
                    6'b001001: return 3'b000;
                    6'b001000: return 3'b100;
                    6'b001101: return 3'b011;
                    default:   return 3'b110;
                endcase
            end
            K_LW, K_SW: return 3'b000;
            K_BR:       return 3'b001;
            default:    return 3'b111;
        endcase
    endfunction

    // Run one instruction from its IF cycle. Entry and exit: at a falling
    // edge with the DUT in S_IF.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input logic s);
        kind_t k;
        int lat_exp, cyc, last_cyc, irw, regw, mrd, mwr;
        logic [1:0] pcsrc_exp, pcsrc_last;
        logic [2:0] alu_last, st_last, st_exp;
        logic ext_l, rdst_l, srca_l, srcb_l, db_l;
        k = classify(o, f);
        cyc = 0; last_cyc = 0; irw = 0; regw = 0; mrd = 0; mwr = 0;
        pcsrc_last = 2'b11; alu_last = 3'bx; st_last = 3'bx;
        ext_l = 1'bx; rdst_l = 1'bx; srca_l = 1'bx; srcb_l = 1'bx; db_l = 1'bx;
        bus_if.op = o; bus_if.func = f; bus_if.zero = z; bus_if.sign = s;
        #1;
        chk("fetch_state", 32'(state), 32'd0);
        while (last_cyc == 0 && cyc < 8) begin
            cyc++;
            if (bus_if.IRWre === 1'b1) irw++;
            if (bus_if.RegWre === 1'b1) regw++;
            if (bus_if.mRD === 1'b1) mrd++;
            if (bus_if.mWR === 1'b1) mwr++;
            if (bus_if.PCWre === 1'b1) begin
                last_cyc   = cyc;
                pcsrc_last = bus_if.PCSrc;
                alu_last   = bus_if.ALUOp;
                st_last    = state;
                ext_l  = bus_if.ExtSel;  rdst_l = bus_if.RegDst;
                srca_l = bus_if.ALUSrcA; srcb_l = bus_if.ALUSrcB;
                db_l   = bus_if.DBDataSrc;
            end
            @(negedge CLK);
        end

        case (k)
            K_J, K_NOP:   begin lat_exp = 2; st_exp = 3'd1; end
            K_BR:         begin lat_exp = 3; st_exp = 3'd6; end
            K_SW:         begin lat_exp = 4; st_exp = 3'd4; end
            K_LW:         begin lat_exp = 5; st_exp = 3'd5; end
            default:      begin lat_exp = 4; st_exp = 3'd3; end
        endcase
        pcsrc_exp = 2'b00;
        if (k == K_J) pcsrc_exp = 2'b10;
        if (k == K_BR) begin
            if ((o == 6'b110000 && z) || (o == 6'b000101 && !z) || (o == 6'b000001 && s))
                pcsrc_exp = 2'b01;
        end
        exp_cnt = exp_cnt + 16'd1;

        chk("latency", 32'(last_cyc), 32'(lat_exp));
        chk("last_state", 32'(st_last), 32'(st_exp));
        chk("pcsrc", 32'(pcsrc_last), 32'(pcsrc_exp));
        chk("aluop", 32'(alu_last), 32'(alu_expect(o, f)));
        chk("irwre_cnt", 32'(irw), 32'd1);
        chk("regwre_cnt", 32'(regw), (k == K_R || k == K_IMM || k == K_LW) ? 32'd1 : 32'd0);
        chk("mrd_cnt", 32'(mrd), (k == K_LW) ? 32'd1 : 32'd0);
        chk("mwr_cnt", 32'(mwr), (k == K_SW) ? 32'd1 : 32'd0);
        if (k == K_R || k == K_IMM || k == K_LW || k == K_SW || k == K_BR) begin
            chk("alusrcb", 32'(srcb_l), (k == K_IMM || k == K_LW || k == K_SW) ? 32'd1 : 32'd0);
            chk("alusrca", 32'(srca_l), (k == K_R && f == 6'b000000) ? 32'd1 : 32'd0);
        end
        if (k == K_R || k == K_IMM || k == K_LW) begin
            chk("regdst", 32'(rdst_l), (k == K_R) ? 32'd1 : 32'd0);
            chk("dbdatasrc", 32'(db_l), (k == K_LW) ? 32'd1 : 32'd0);
        end
        if (k == K_IMM || k == K_LW || k == K_SW || k == K_BR) begin
            chk("extsel", 32'(ext_l), (o == 6'b001000 || o == 6'b001101) ? 32'd0 : 32'd1);
        end
        chk("back_to_if", 32'(state), 32'd0);
        chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
        $display("instr op=%b func=%b zero=%b sign=%b cycles=%0d pcsrc=%b aluop=%b cnt=%0d",
                 o, f, z, s, last_cyc, pcsrc_last, alu_last, instr_cnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
        chk({tag, "_pcwre"}, 32'(bus_if.PCWre), 32'd0);
        chk({tag, "_irwre"}, 32'(bus_if.IRWre), 32'd0);
        chk({tag, "_regwre"}, 32'(bus_if.RegWre), 32'd0);
        chk({tag, "_mrd"}, 32'(bus_if.mRD), 32'd0);
        chk({tag, "_mwr"}, 32'(bus_if.mWR), 32'd0);
        chk({tag, "_pcsrc"}, 32'(bus_if.PCSrc), 32'd0);
        chk({tag, "_aluop"}, 32'(bus_if.ALUOp), 32'd7);
    endtask

    logic [5:0] legal_ops [11];
    logic [5:0] r_funcs [5];

    initial begin
        logic [5:0] o, f;
        int pick;
        legal_ops = '{6'b000000, 6'b001001, 6'b001000, 6'b001101, 6'b001010, 6'b100011,
                      6'b101011, 6'b110000, 6'b000101, 6'b000001, 6'b000010};
        r_funcs   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000};

        Reset = 1'b0;
        bus_if.op = 6'b001001; bus_if.func = 6'd0; bus_if.zero = 1'b0; bus_if.sign = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk_reset_outputs("reset");
        chk("insmemrw", 32'(bus_if.InsMemRw), 32'd1);
        Reset = 1'b1;

        // Directed instructions
        run_instr(6'b001001, 6'b000000, 1'b0, 1'b0);   // addiu
        run_instr(6'b100011, 6'b000000, 1'b0, 1'b0);   // lw
        run_instr(6'b101011, 6'b000000, 1'b0, 1'b0);   // sw
        run_instr(6'b110000, 6'b000000, 1'b1, 1'b0);   // beq taken
        run_instr(6'b000101, 6'b000000, 1'b1, 1'b0);   // bne not taken
        run_instr(6'b000001, 6'b000000, 1'b0, 1'b1);   // bltz taken
        run_instr(6'b000010, 6'b000000, 1'b0, 1'b0);   // j
        run_instr(6'b011111, 6'b000000, 1'b0, 1'b0);   // illegal -> NOP
        run_instr(6'b000000, 6'b000000, 1'b0, 1'b0);   // sll

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 11);
            if (pick == 11) begin
                o = 6'($urandom);
                while (o == 6'b000000 || classify(o, 6'd0) != K_NOP) o = 6'($urandom);
                f = 6'($urandom);
            end else begin
                o = legal_ops[pick];
                f = (o == 6'b000000) ? r_funcs[$urandom_range(0, 4)] : 6'($urandom);
            end
            run_instr(o, f, 1'($urandom), 1'($urandom));
        end

        // Halt: parks with no PC pulses and a frozen counter
        bus_if.op = 6'b111111;
        @(negedge CLK);
        #1;
        chk("halt_id_state", 32'(state), 32'd1);
        chk("halt_id_pcwre", 32'(bus_if.PCWre), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("halt_state", 32'(state), 32'd7);
            chk("halt_pcwre", 32'(bus_if.PCWre), 32'd0);
        end
        chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
        $display("instr op=111111 halted cnt=%0d", instr_cnt);
        Reset = 1'b0;
        #1;
        exp_cnt = 16'd0;
        chk_reset_outputs("halt_reset");
        @(negedge CLK);
        Reset = 1'b1;

        // Reset asserted while sw is in S_MEM: the write strobe must drop at once
        run_instr(6'b001101, 6'b000000, 1'b0, 1'b0);   // ori, so the counter is non-zero
        bus_if.op = 6'b101011;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("mem_state", 32'(state), 32'd4);
        chk("mem_mwr", 32'(bus_if.mWR), 32'd1);
        Reset = 1'b0;
        #1;
        exp_cnt = 16'd0;
        chk_reset_outputs("midreset");
        $display("instr op=101011 abandoned in MEM by reset cnt=%0d", instr_cnt);
        @(negedge CLK);
        Reset = 1'b1;

        // Fetch resumes normally after release
        run_instr(6'b011111, 6'b000000, 1'b0, 1'b0);
        run_instr(6'b100011, 6'b000000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
